// File: rtl/reverse_bits_stream.sv
// Registered bit-permutation stage with a 2-entry skid buffer on a valid/ready stream.
// Optional macro REV_STATS_EN adds an output-transfer counter on o_xfer_cnt.
module reverse_bits_stream #(
  parameter int W     = 16,
  parameter int GRP   = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [W-1:0]     i_in_data,
  input  logic [1:0]       i_in_mode,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [W-1:0]     o_out_data,
  output logic [1:0]       o_out_mode
`ifdef REV_STATS_EN
  ,
  output logic [CNT_W-1:0] o_xfer_cnt
`endif
);

  generate
    if (GRP < 1 || GRP > W || (W % GRP) != 0) begin : g_bad_grp
      $error("reverse_bits_stream: W must be a multiple of GRP with 1 <= GRP <= W");
    end
    if (CNT_W < 1) begin : g_bad_cnt
      $error("reverse_bits_stream: CNT_W must be at least 1");
    end
  endgenerate

  function automatic logic [W-1:0] f_perm(input logic [W-1:0] d, input logic [1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      case (m)
        2'd0:    r[i] = d[i];
        2'd1:    r[i] = d[W-1-i];
        2'd2:    r[i] = d[(i/GRP)*GRP + GRP-1 - (i%GRP)];
        default: r[i] = d[(W/GRP-1 - i/GRP)*GRP + (i%GRP)];
      endcase
    end
    return r;
  endfunction

  logic         r_m_vld, r_s_vld;
  logic [W-1:0] r_m_data, r_s_data;
  logic [1:0]   r_m_mode, r_s_mode;
  logic [W-1:0] w_perm;
  logic         w_push, w_pop;

  assign w_perm = f_perm(i_in_data, i_in_mode);
  assign w_push = i_in_valid & ~r_s_vld;
  assign w_pop  = r_m_vld & i_out_ready;

  // S only ever fills while M is held, so M is always the FIFO head.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_m_vld  <= 1'b0;
      r_m_data <= '0;
      r_m_mode <= 2'd0;
      r_s_vld  <= 1'b0;
      r_s_data <= '0;
      r_s_mode <= 2'd0;
    end else if (!r_m_vld || w_pop) begin
      if (r_s_vld) begin
        r_m_vld  <= 1'b1;
        r_m_data <= r_s_data;
        r_m_mode <= r_s_mode;
        r_s_vld  <= w_push;
        if (w_push) begin
          r_s_data <= w_perm;
          r_s_mode <= i_in_mode;
        end
      end else begin
        r_m_vld <= w_push;
        if (w_push) begin
          r_m_data <= w_perm;
          r_m_mode <= i_in_mode;
        end
      end
    end else if (w_push) begin
      r_s_vld  <= 1'b1;
      r_s_data <= w_perm;
      r_s_mode <= i_in_mode;
    end
  end

  assign o_in_ready  = ~r_s_vld;
  assign o_out_valid = r_m_vld;
  assign o_out_data  = r_m_data;
  assign o_out_mode  = r_m_mode;

`ifdef REV_STATS_EN
  logic [CNT_W-1:0] r_xfer_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   r_xfer_cnt <= '0;
    else if (w_pop) r_xfer_cnt <= r_xfer_cnt + 1'b1;
  end
  assign o_xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_reverse_bits_stream.sv
// Bench for reverse_bits_stream: directed steps plus randomized traffic against a
// depth-2 FIFO reference model with group-arithmetic permutation.
module tb_reverse_bits_stream;
  localparam int W = 16;
  localparam int GRP = 4;
  localparam int CNT_W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [1:0]    in_mode, out_mode;
`ifdef REV_STATS_EN
  logic [CNT_W-1:0] xfer_cnt;
`endif

  always #5 clk = ~clk;

  reverse_bits_stream #(.W(W), .GRP(GRP), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_mode(in_mode),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_mode(out_mode)
`ifdef REV_STATS_EN
    , .o_xfer_cnt(xfer_cnt)
`endif
  );

  typedef struct { logic [W-1:0] d; logic [1:0] m; } exp_t;
  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pop = 0;
  int   n_out_cyc = 0;

  function automatic int rev_int(int v, int nb);
    int r = 0;
    for (int k = 0; k < nb; k++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] ref_perm(logic [W-1:0] d, logic [1:0] m);
    int ng   = W / GRP;
    int dv   = int'(d);
    int mask = (1 << GRP) - 1;
    int r    = 0;
    case (m)
      2'd0: r = dv;
      2'd1: r = rev_int(dv, W);
      2'd2: for (int g = 0; g < ng; g++) r |= rev_int((dv >> (g*GRP)) & mask, GRP) << (g*GRP);
      default: for (int g = 0; g < ng; g++) r |= ((dv >> (g*GRP)) & mask) << ((ng-1-g)*GRP);
    endcase
    return r[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with inputs set: check outputs, clock once, update model.
  task automatic cyc();
    bit fin, fout;
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    if (q.size() > 0) begin
      chk("out_data", {16'd0, out_data}, {16'd0, q[0].d});
      chk("out_mode", {30'd0, out_mode}, {30'd0, q[0].m});
    end
`ifdef REV_STATS_EN
    chk("xfer_cnt", {16'd0, xfer_cnt}, n_pop % (1 << CNT_W));
`endif
    fin  = in_valid && (q.size() < 2);
    fout = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      n_pop = 0;
    end else begin
      if (fout) begin
        void'(q.pop_front());
        n_pop++;
        n_out_cyc++;
      end
      if (fin) q.push_back('{ref_perm(in_data, in_mode), in_mode});
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [1:0] m, input logic r);
    in_valid = v; in_data = d; in_mode = m; out_ready = r;
  endtask

  initial begin
    logic [W-1:0] pat;
    int sent, budget, start;
    pat = 16'b1000000001111000;
    rst_n = 1'b0;
    drive(1'b0, '0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_mode", {30'd0, out_mode}, 32'd0);
    cyc();

    // Known-answer permutations.
    drive(1'b1, pat, 2'd1, 1'b1); cyc();
    chk("t1_data", {16'd0, out_data}, {16'd0, 16'b0001111000000001});
    chk("t1_mode", {30'd0, out_mode}, 32'd1);
    drive(1'b1, pat, 2'd2, 1'b1); cyc();
    chk("t2_mode2", {16'd0, out_data}, {16'd0, 16'b0001000011100001});
    drive(1'b1, pat, 2'd3, 1'b1); cyc();
    chk("t2_mode3", {16'd0, out_data}, {16'd0, 16'b1000011100001000});
    drive(1'b1, 16'h1234, 2'd0, 1'b1); cyc();
    chk("t2_mode0", {16'd0, out_data}, 32'h1234);
    drive(1'b0, '0, 2'd0, 1'b1); cyc();

    // Backpressure: A,B accepted, C held until space frees.
    drive(1'b1, 16'hA001, 2'd1, 1'b0); cyc();
    drive(1'b1, 16'hB002, 2'd2, 1'b0); cyc();
    chk("t3_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 16'hC003, 2'd3, 1'b0); cyc(); cyc();
    chk("t3_hold", {16'd0, out_data}, {16'd0, ref_perm(16'hA001, 2'd1)});
    out_ready = 1'b1;
    budget = 0;
    while (q.size() < 2 && budget < 0) budget++;
    cyc();
    cyc();
    in_valid = 1'b0;
    budget = 0;
    while (q.size() > 0 && budget < 20) begin cyc(); budget++; end
    chk("t3_drain", {31'd0, out_valid}, 32'd0);

    // Full-rate streaming of 8 words.
    start = n_out_cyc;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(i * 16'h1357 + 16'h0F0F), 2'(i), 1'b1);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    chk("t4_count", n_out_cyc - start, 32'd8);

    // Reset with both entries full.
    drive(1'b1, 16'h5A5A, 2'd1, 1'b0); cyc();
    drive(1'b1, 16'h6B6B, 2'd2, 1'b0); cyc();
    rst_n = 1'b0; cyc();
    rst_n = 1'b1;
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 16'h0001, 2'd1, 1'b1); cyc();
    chk("t5_lat", {16'd0, out_data}, 32'h8000);
    in_valid = 1'b0; cyc();

    // Randomized traffic.
    sent = 0;
    budget = 0;
    while (sent < 1000 && budget < 20000) begin
      drive(($urandom % 4) != 0, 16'($urandom), 2'($urandom), ($urandom % 3) != 0);
      if (in_valid && q.size() < 2) sent++;
      cyc();
      budget++;
    end
    chk("rnd_sent", sent, 32'd1000);
    drive(1'b0, '0, 2'd0, 1'b1);
    budget = 0;
    while (q.size() > 0 && budget < 20) begin cyc(); budget++; end
    cyc();
    chk("rnd_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
